// File: rtl/pc_unit_pkg.sv
// -----------------------------------------------------------------------------
// pc_unit_pkg
// Shared definitions for the program-counter stage:
//   pc_state_e        - FSM states (BOOT, RUN, HALT)
//   XLEN_DEFAULT      - default datapath width
//   RESET_PC_DEFAULT  - default PC loaded on reset
//   PC_STEP           - sequential fetch increment (bytes)
// -----------------------------------------------------------------------------
package pc_unit_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          PC_STEP          = 4;

endpackage : pc_unit_pkg

// File: rtl/pc_unit_if.sv
// -----------------------------------------------------------------------------
// pc_unit_if
// Bundles the redirect request and the fetch handshake of the PC stage.
//   Redirect side : stall, jump, jalr, jump_base, jump_imm
//   Fetch side    : pc, pc_plus4, pc_valid, fetch_ready
//   Status        : flush, trap
// Modports:
//   master - the PC stage itself (drives pc/pc_plus4/pc_valid/flush/trap)
//   slave  - the surrounding pipeline / fetch unit
// -----------------------------------------------------------------------------
interface pc_unit_if
  import pc_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) ();

  logic            stall;
  logic            jump;
  logic            jalr;
  logic [XLEN-1:0] jump_base;
  logic [XLEN-1:0] jump_imm;
  logic            fetch_ready;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            pc_valid;
  logic            flush;
  logic            trap;

  modport master (
    input  stall, jump, jalr, jump_base, jump_imm, fetch_ready,
    output pc, pc_plus4, pc_valid, flush, trap
  );

  modport slave (
    output stall, jump, jalr, jump_base, jump_imm, fetch_ready,
    input  pc, pc_plus4, pc_valid, flush, trap
  );

endinterface : pc_unit_if

// File: rtl/pc_unit_target_adder.sv
// -----------------------------------------------------------------------------
// pc_target_adder
// Combinational jump-target generator, also shared with branch-compare logic.
//   jump_base  in  XLEN  base operand (PC or register)
//   jump_imm   in  XLEN  sign-extended offset
//   jalr       in  1     clear bit 0 of the sum (JALR semantics)
//   target     out XLEN  (jump_base + jump_imm) mod 2^XLEN, bit 0 cleared for JALR
//   misaligned out 1     target is not 4-byte aligned after the JALR masking
// -----------------------------------------------------------------------------
module pc_target_adder
  import pc_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] jump_base,
  input  logic [XLEN-1:0] jump_imm,
  input  logic            jalr,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  logic [XLEN-1:0] sum_s;

  // Carry out of the top bit is intentionally dropped.
  assign sum_s = jump_base + jump_imm;

  // Apply JALR bit-0 clearing after the add.
  always_comb begin
    target = sum_s;
    if (jalr) begin
      target[0] = 1'b0;
    end else begin
      target[0] = sum_s[0];
    end
  end

  // For JALR bit 0 is already zero, so only bit 1 can flag it there.
  assign misaligned = target[1] | target[0];

endmodule : pc_target_adder

// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit
// Program-counter stage downstream of the JALR base-select mux. Holds the
// architectural PC, presents it to fetch with a valid/ready handshake,
// redirects on jumps (one-cycle latency) and pulses flush after each redirect.
//
// Ports:
//   clk    in  1   system clock, rising edge
//   rst_n  in  1   asynchronous active-low reset
//   bus    pc_unit_if.master
//          stall, jump, jalr, jump_base, jump_imm, fetch_ready  (inputs)
//          pc, pc_plus4, pc_valid, flush, trap                  (outputs)
//
// Build option:
//   PC_MISALIGN_TRAP_EN defined   - misaligned jump target halts the stage
//                                   (pc = faulting target, trap = 1, exits
//                                   only through reset).
//   PC_MISALIGN_TRAP_EN undefined - target[1:0] forced to 2'b00, trap = 0.
// -----------------------------------------------------------------------------
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic        clk,
  input  logic        rst_n,
  pc_unit_if.master   bus
);

  localparam logic [XLEN-1:0] STEP_W = XLEN'(PC_STEP);

  pc_state_e       state_r;
  logic [XLEN-1:0] pc_r;
  logic            pc_valid_r;
  logic            flush_r;
  logic            trap_r;

  logic [XLEN-1:0] target_s;
  logic            misaligned_s;
  logic [XLEN-1:0] redirect_pc_s;
  logic            trap_hit_s;

  pc_target_adder #(
    .XLEN (XLEN)
  ) u_target_adder (
    .jump_base  (bus.jump_base),
    .jump_imm   (bus.jump_imm),
    .jalr       (bus.jalr),
    .target     (target_s),
    .misaligned (misaligned_s)
  );

`ifdef PC_MISALIGN_TRAP_EN
  // A misaligned target halts the stage; the faulting address is kept in pc.
  assign trap_hit_s    = misaligned_s;
  assign redirect_pc_s = target_s;
`else
  // Misaligned targets are silently aligned down to a word boundary.
  assign trap_hit_s    = 1'b0;
  assign redirect_pc_s = misaligned_s ? {target_s[XLEN-1:2], 2'b00} : target_s;
`endif

  // PC stage FSM with all status outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= BOOT;
      pc_r       <= RESET_PC;
      pc_valid_r <= 1'b0;
      flush_r    <= 1'b0;
      trap_r     <= 1'b0;
    end else begin
      case (state_r)
        // One idle cycle after reset; stall does not delay leaving BOOT.
        BOOT: begin
          state_r    <= RUN;
          pc_valid_r <= 1'b1;
          flush_r    <= 1'b0;
        end

        RUN: begin
          flush_r <= 1'b0;
          // Under stall a jump is dropped; upstream re-presents it later.
          if (!bus.stall) begin
            if (bus.jump) begin
              // Redirect never waits for fetch_ready; the pending fetch is dropped.
              flush_r <= 1'b1;
              if (trap_hit_s) begin
                state_r    <= HALT;
                pc_r       <= redirect_pc_s;
                pc_valid_r <= 1'b0;
                trap_r     <= 1'b1;
              end else begin
                pc_r <= redirect_pc_s;
              end
            end else if (bus.fetch_ready) begin
              pc_r <= pc_r + STEP_W;
            end
          end
        end

        // Terminal until reset: pc frozen, no fetch, trap stays as entered.
        HALT: begin
          pc_valid_r <= 1'b0;
          flush_r    <= 1'b0;
          trap_r     <= trap_r;
        end

        default: begin
          state_r    <= BOOT;
          pc_r       <= RESET_PC;
          pc_valid_r <= 1'b0;
          flush_r    <= 1'b0;
          trap_r     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc       = pc_r;
  assign bus.pc_plus4 = pc_r + STEP_W;
  assign bus.pc_valid = pc_valid_r;
  assign bus.flush    = flush_r;
  assign bus.trap     = trap_r;

endmodule : pc_unit
